// File: rtl/hdmi_cfg_pkg.sv
// rtl/hdmi_cfg_pkg.sv - shared types and entry layout for the HDMI I2C configuration sequencer
package hdmi_cfg_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_WAIT_HPD,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_RETRY_WAIT,
    ST_DONE,
    ST_FAIL
  } cfg_state_e;

  localparam int ENTRY_W = 24;

  // Table entry layout: {slave, reg, data}
  localparam int SLV_HI = 23;
  localparam int SLV_LO = 16;
  localparam int REG_HI = 15;
  localparam int REG_LO = 8;
  localparam int DAT_HI = 7;
  localparam int DAT_LO = 0;

  function automatic logic [ENTRY_W-1:0] entry_pack(input logic [7:0] slv,
                                                    input logic [7:0] rg,
                                                    input logic [7:0] dat);
    logic [ENTRY_W-1:0] e;
    e = '0;
    e[SLV_HI:SLV_LO] = slv;
    e[REG_HI:REG_LO] = rg;
    e[DAT_HI:DAT_LO] = dat;
    return e;
  endfunction

endpackage

// File: rtl/hdmi_cfg_rom.sv
// rtl/hdmi_cfg_rom.sv - HDMI transmitter register table with a one-cycle registered read
module hdmi_cfg_rom
  import hdmi_cfg_pkg::*;
#(
  parameter int TABLE_LEN = 31,
  parameter int IW        = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [IW-1:0]      addr,
  output logic [ENTRY_W-1:0] data
);

  logic [31:0]        addr_w;
  logic [ENTRY_W-1:0] entry;
  logic [ENTRY_W-1:0] data_d;
  logic [ENTRY_W-1:0] data_q;

  // Transmitter bring-up values (slave 0x72); addresses past the table read as zero
  always_comb begin
    addr_w = 32'(addr);
    entry  = '0;
    case (addr_w)
      32'd0:  entry = entry_pack(8'h72, 8'h41, 8'h10);
      32'd1:  entry = entry_pack(8'h72, 8'h98, 8'h03);
      32'd2:  entry = entry_pack(8'h72, 8'h9A, 8'hE0);
      32'd3:  entry = entry_pack(8'h72, 8'h9C, 8'h30);
      32'd4:  entry = entry_pack(8'h72, 8'h9D, 8'h61);
      32'd5:  entry = entry_pack(8'h72, 8'hA2, 8'hA4);
      32'd6:  entry = entry_pack(8'h72, 8'hA3, 8'hA4);
      32'd7:  entry = entry_pack(8'h72, 8'hE0, 8'hD0);
      32'd8:  entry = entry_pack(8'h72, 8'hF9, 8'h00);
      32'd9:  entry = entry_pack(8'h72, 8'h15, 8'h00);
      32'd10: entry = entry_pack(8'h72, 8'h16, 8'h30);
      32'd11: entry = entry_pack(8'h72, 8'h17, 8'h00);
      32'd12: entry = entry_pack(8'h72, 8'h18, 8'h46);
      32'd13: entry = entry_pack(8'h72, 8'hAF, 8'h06);
      32'd14: entry = entry_pack(8'h72, 8'hBA, 8'h60);
      32'd15: entry = entry_pack(8'h72, 8'hD0, 8'h3C);
      32'd16: entry = entry_pack(8'h72, 8'hD6, 8'hC0);
      32'd17: entry = entry_pack(8'h72, 8'hDE, 8'h9C);
      32'd18: entry = entry_pack(8'h72, 8'hE4, 8'h60);
      32'd19: entry = entry_pack(8'h72, 8'hFA, 8'h7D);
      32'd20: entry = entry_pack(8'h72, 8'h55, 8'h10);
      32'd21: entry = entry_pack(8'h72, 8'h56, 8'h08);
      32'd22: entry = entry_pack(8'h72, 8'h3C, 8'h10);
      32'd23: entry = entry_pack(8'h72, 8'h3B, 8'h80);
      32'd24: entry = entry_pack(8'h72, 8'h48, 8'h08);
      32'd25: entry = entry_pack(8'h72, 8'h49, 8'hA8);
      32'd26: entry = entry_pack(8'h72, 8'h4C, 8'h00);
      32'd27: entry = entry_pack(8'h72, 8'h94, 8'hC0);
      32'd28: entry = entry_pack(8'h72, 8'h96, 8'hF0);
      32'd29: entry = entry_pack(8'h72, 8'hD5, 8'h00);
      32'd30: entry = entry_pack(8'h72, 8'h40, 8'h80);
      default: entry = '0;
    endcase
    data_d = (addr_w < 32'(TABLE_LEN)) ? entry : '0;
  end

  // Registered read port
  always_ff @(posedge clk) begin
    if (!reset_n) data_q <= '0;
    else          data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/hdmi_i2c_config_seq.sv
// rtl/hdmi_i2c_config_seq.sv - walks the register table through the single-write I2C engine
module hdmi_i2c_config_seq
  import hdmi_cfg_pkg::*;
#(
  parameter int  TABLE_LEN      = 31,
  parameter int  POWERUP_CYCLES = 1000000,
  parameter int  RETRY_MAX      = 3,
  parameter int  RETRY_GAP      = 5000,
  parameter int  WDOG_CYCLES    = 65535,
  parameter int  AUTO_START     = 1,
  localparam int IW             = (TABLE_LEN > 1) ? $clog2(TABLE_LEN) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cfg_start,
  input  logic          hpd,
  output logic          i2c_req,
  output logic [23:0]   i2c_data,
  input  logic          i2c_done,
  input  logic          i2c_nack,
  output logic          cfg_busy,
  output logic          cfg_done,
  output logic          cfg_error,
  output logic [IW-1:0] cfg_index
);

  localparam logic [31:0]   PWR_LAST  = 32'(POWERUP_CYCLES - 1);
  localparam logic [31:0]   GAP_LAST  = 32'(RETRY_GAP - 1);
  localparam logic [31:0]   WDOG_LAST = 32'(WDOG_CYCLES - 1);
  localparam logic [31:0]   CNT_MAX   = '1;
  localparam logic [7:0]    RETRY_LIM = 8'(RETRY_MAX);
  localparam logic [IW-1:0] IDX_LAST  = IW'(TABLE_LEN - 1);

  cfg_state_e         state_q, state_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [31:0]        wdog_q, wdog_d;
  logic [7:0]         retry_q, retry_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [ENTRY_W-1:0] data_q, data_d;
  logic               start_seen_q, start_seen_d;
  logic               hpd_lost_q, hpd_lost_d;
  logic               hpd_meta_q, hpd_s_q;
  logic [ENTRY_W-1:0] rom_data;
  logic               busy;
  logic               lost;
  logic               wdog_exp;
  logic               start_ok;

  // ROM is addressed with the next index so its registered word is ready during LOAD
  hdmi_cfg_rom #(
    .TABLE_LEN (TABLE_LEN),
    .IW        (IW)
  ) u_rom (
    .clk     (clk),
    .reset_n (reset_n),
    .addr    (idx_d),
    .data    (rom_data)
  );

  assign busy     = (state_q == ST_LOAD) || (state_q == ST_ISSUE) ||
                    (state_q == ST_WAIT_DONE) || (state_q == ST_RETRY_WAIT);
  assign lost     = hpd_lost_q || !hpd_s_q;
  assign wdog_exp = (wdog_q == WDOG_LAST);
  assign start_ok = (AUTO_START != 0) || start_seen_q || cfg_start;

  // Two-flop synchroniser for the raw hot-plug detect
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hpd_meta_q <= 1'b0;
      hpd_s_q    <= 1'b0;
    end else begin
      hpd_meta_q <= hpd;
      hpd_s_q    <= hpd_meta_q;
    end
  end

  // Next-state, counter and capture logic for the table walk
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wdog_d       = wdog_q;
    retry_d      = retry_q;
    idx_d        = idx_q;
    data_d       = data_q;
    start_seen_d = start_seen_q;
    hpd_lost_d   = hpd_lost_q;

    case (state_q)
      ST_PWRUP: begin
        if (cnt_q == PWR_LAST) begin
          state_d = ST_WAIT_HPD;
          cnt_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_WAIT_HPD: begin
        if (hpd_s_q && start_ok) begin
          state_d = ST_LOAD;
          idx_d   = '0;
          retry_d = '0;
        end
      end
      ST_LOAD: begin
        // Nothing is on the bus yet, so a lost sink simply abandons the walk
        if (lost) begin
          state_d = ST_WAIT_HPD;
        end else begin
          data_d  = rom_data;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wdog_d  = '0;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (wdog_q != CNT_MAX) wdog_d = wdog_q + 32'd1;
        if (i2c_done || wdog_exp) begin
          if (lost) begin
            state_d = ST_WAIT_HPD;
          end else if (i2c_done && !i2c_nack) begin
            if (idx_q == IDX_LAST) begin
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + 1'b1;
              retry_d = '0;
              state_d = ST_LOAD;
            end
          end else if (retry_q < RETRY_LIM) begin
            retry_d = retry_q + 8'd1;
            cnt_d   = '0;
            state_d = ST_RETRY_WAIT;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_RETRY_WAIT: begin
        if (lost) begin
          state_d = ST_WAIT_HPD;
        end else if (cnt_q == GAP_LAST) begin
          state_d = ST_ISSUE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_DONE: begin
        if (cfg_start || !hpd_s_q) state_d = ST_WAIT_HPD;
      end
      ST_FAIL: begin
        if (cfg_start) state_d = ST_WAIT_HPD;
      end
      default: state_d = ST_PWRUP;
    endcase

    if (state_d == ST_WAIT_HPD) hpd_lost_d = 1'b0;
    else if (busy && !hpd_s_q)  hpd_lost_d = 1'b1;

    if (state_d == ST_LOAD)         start_seen_d = 1'b0;
    else if (cfg_start && !busy)    start_seen_d = 1'b1;
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_PWRUP;
      cnt_q        <= '0;
      wdog_q       <= '0;
      retry_q      <= '0;
      idx_q        <= '0;
      data_q       <= '0;
      start_seen_q <= 1'b0;
      hpd_lost_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wdog_q       <= wdog_d;
      retry_q      <= retry_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      start_seen_q <= start_seen_d;
      hpd_lost_q   <= hpd_lost_d;
    end
  end

  assign i2c_req   = (state_q == ST_ISSUE);
  assign i2c_data  = data_q;
  assign cfg_busy  = busy;
  assign cfg_done  = (state_q == ST_DONE);
  assign cfg_error = (state_q == ST_FAIL);
  assign cfg_index = idx_q;

endmodule

// File: tb/tb_hdmi_i2c_config_seq.sv
// tb/tb_hdmi_i2c_config_seq.sv - randomized self-checking bench for hdmi_i2c_config_seq
module tb_hdmi_i2c_config_seq;

  localparam int TL    = 31;
  localparam int PWR   = 20;
  localparam int RMAX  = 3;
  localparam int GAP   = 30;
  localparam int WDOG  = 100;
  localparam int IW    = 5;
  localparam int BUDGET = 20000;

  logic          clk;
  logic          reset_n;
  logic          cfg_start;
  logic          hpd;
  logic          i2c_req;
  logic [23:0]   i2c_data;
  logic          i2c_done;
  logic          i2c_nack;
  logic          cfg_busy;
  logic          cfg_done;
  logic          cfg_error;
  logic [IW-1:0] cfg_index;

  hdmi_i2c_config_seq #(
    .TABLE_LEN      (TL),
    .POWERUP_CYCLES (PWR),
    .RETRY_MAX      (RMAX),
    .RETRY_GAP      (GAP),
    .WDOG_CYCLES    (WDOG),
    .AUTO_START     (1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cfg_start (cfg_start),
    .hpd       (hpd),
    .i2c_req   (i2c_req),
    .i2c_data  (i2c_data),
    .i2c_done  (i2c_done),
    .i2c_nack  (i2c_nack),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done),
    .cfg_error (cfg_error),
    .cfg_index (cfg_index)
  );

  // Expected transmitter table, in walk order
  logic [23:0] tbl [0:TL-1] = '{
    24'h724110, 24'h729803, 24'h729AE0, 24'h729C30, 24'h729D61, 24'h72A2A4,
    24'h72A3A4, 24'h72E0D0, 24'h72F900, 24'h721500, 24'h721630, 24'h721700,
    24'h721846, 24'h72AF06, 24'h72BA60, 24'h72D03C, 24'h72D6C0, 24'h72DE9C,
    24'h72E460, 24'h72FA7D, 24'h725510, 24'h725608, 24'h723C10, 24'h723B80,
    24'h724808, 24'h7249A8, 24'h724C00, 24'h7294C0, 24'h7296F0, 24'h72D500,
    24'h724080
  };

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [23:0] log_data [$];
  int          log_idx  [$];
  int          log_cyc  [$];
  int          exp_q    [$];
  bit          exp_err;

  bit          eng_busy   = 0;
  bit          eng_nack   = 0;
  bit          eng_silent = 0;
  bit          nack_all   = 0;
  int          eng_cnt    = 0;
  int          nack_entry = -1;
  int          nacks_left = 0;
  int          lat_min    = 40;
  int          lat_max    = 40;
  logic [23:0] eng_data   = '0;
  bit          prev_req   = 0;
  int          wide_req   = 0;
  int          unstable   = 0;
  int          req_hpd_low = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  // Engine model: logs each request, answers after a random latency with ACK/NACK or not at all
  always @(negedge clk) begin
    i2c_done = 1'b0;
    i2c_nack = 1'b0;
    if (!reset_n) begin
      eng_busy = 0;
    end else begin
      if (eng_busy) begin
        if (i2c_data !== eng_data) unstable++;
        if (eng_cnt <= 1) begin
          eng_busy = 0;
          if (!eng_silent) begin
            i2c_done = 1'b1;
            i2c_nack = eng_nack;
          end
        end else begin
          eng_cnt--;
        end
      end
      if (i2c_req) begin
        if (prev_req) wide_req++;
        if (!hpd) req_hpd_low++;
        log_data.push_back(i2c_data);
        log_idx.push_back(int'(cfg_index));
        log_cyc.push_back(cyc);
        eng_busy = 1;
        eng_data = i2c_data;
        eng_cnt  = int'($urandom_range(lat_max, lat_min));
        eng_nack = nack_all;
        if (nack_entry >= 0 && nacks_left > 0) begin
          if (i2c_data == tbl[nack_entry]) begin
            eng_nack = 1;
            nacks_left--;
          end
        end
      end
    end
    prev_req = i2c_req;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: each entry is tried once plus its NACK count, capped at RETRY_MAX+1 tries, then FAIL
  task automatic build_exp(input int ne, input int nk);
    int tries;
    exp_q.delete();
    exp_err = 0;
    for (int e = 0; e < TL; e++) begin
      tries = (e == ne) ? nk + 1 : 1;
      if (tries > RMAX + 1) begin
        for (int k = 0; k <= RMAX; k++) exp_q.push_back(e);
        exp_err = 1;
        return;
      end
      for (int k = 0; k < tries; k++) exp_q.push_back(e);
    end
  endtask

  task automatic clear_log();
    log_data.delete();
    log_idx.delete();
    log_cyc.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    clear_log();
  endtask

  task automatic wait_outcome(input string tag);
    int n;
    n = 0;
    while (!(cfg_done || cfg_error) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) chk({tag, "_timeout"}, 1, 0);
  endtask

  task automatic wait_reqs(input string tag, input int cnt);
    int n;
    n = 0;
    while (log_data.size() < cnt && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) chk({tag, "_req_timeout"}, 1, 0);
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_count"}, log_data.size(), exp_q.size());
    for (int i = 0; i < log_data.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), log_data[i], tbl[exp_q[i]]);
      chk($sformatf("%s_idx%0d", tag, i), log_idx[i], exp_q[i]);
    end
  endtask

  task automatic check_gaps(input string tag);
    for (int i = 1; i < log_data.size(); i++) begin
      if (log_idx[i] == log_idx[i-1])
        chk($sformatf("%s_gap%0d", tag, i), (log_cyc[i] - log_cyc[i-1]) >= GAP, 1);
    end
  endtask

  task automatic run_check(input string tag);
    wait_outcome(tag);
    check_log(tag);
    chk({tag, "_done"}, cfg_done, !exp_err);
    chk({tag, "_error"}, cfg_error, exp_err);
  endtask

  initial begin
    int k;
    int n;
    int ne;
    int nk;
    reset_n   = 1'b0;
    cfg_start = 1'b0;
    hpd       = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req", i2c_req, 0);
    chk("rst_data", i2c_data, 0);
    chk("rst_busy", cfg_busy, 0);
    chk("rst_done", cfg_done, 0);
    chk("rst_error", cfg_error, 0);
    chk("rst_index", cfg_index, 0);
    hpd = 1'b1;

    // 1: every write ACKed after 40 cycles
    lat_min = 40; lat_max = 40;
    do_reset();
    build_exp(-1, 0);
    run_check("t1");
    chk("t1_index_last", cfg_index, TL - 1);
    chk("t1_busy", cfg_busy, 0);

    // 2: entry 5 NACKs twice then ACKs
    lat_min = 5; lat_max = 60;
    nack_entry = 5; nacks_left = 2;
    do_reset();
    build_exp(5, 2);
    run_check("t2");
    check_gaps("t2");

    // 3: entry 0 always NACKs, then restart via cfg_start
    nack_entry = -1; nack_all = 1;
    do_reset();
    build_exp(0, 1000);
    run_check("t3");
    check_gaps("t3");
    nack_all = 0;
    clear_log();
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    @(negedge clk);
    chk("t3_err_cleared", cfg_error, 0);
    build_exp(-1, 0);
    run_check("t3r");

    // 4: engine never answers; watchdog timeouts count as NACKs
    eng_silent = 1;
    do_reset();
    build_exp(0, 1000);
    run_check("t4");
    for (int i = 1; i < log_cyc.size(); i++)
      chk($sformatf("t4_tmo_gap%0d", i), log_cyc[i] - log_cyc[i-1], WDOG + GAP + 1);
    eng_silent = 0;

    // 5: HPD drops while entry 10 is in flight, then returns
    lat_min = 40; lat_max = 40;
    do_reset();
    wait_reqs("t5", 11);
    repeat ($urandom_range(20, 1)) @(negedge clk);
    hpd = 1'b0;
    n = 0;
    while (eng_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    chk("t5_busy_lost", cfg_busy, 0);
    chk("t5_done_lost", cfg_done, 0);
    repeat (50) @(negedge clk);
    hpd = 1'b1;
    exp_q.delete();
    for (int i = 0; i <= 10; i++) exp_q.push_back(i);
    for (int i = 0; i < TL; i++) exp_q.push_back(i);
    exp_err = 0;
    wait_outcome("t5");
    check_log("t5");
    chk("t5_done", cfg_done, 1);
    chk("t5_req_hpd_low", req_hpd_low, 0);

    // 6: one-cycle reset while waiting on the engine
    lat_min = 40; lat_max = 40;
    do_reset();
    k = int'($urandom_range(20, 0));
    wait_reqs("t6", k + 1);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("t6_req", i2c_req, 0);
    chk("t6_data", i2c_data, 0);
    chk("t6_busy", cfg_busy, 0);
    chk("t6_done", cfg_done, 0);
    chk("t6_error", cfg_error, 0);
    chk("t6_index", cfg_index, 0);
    clear_log();
    n = 0;
    while (log_data.size() == 0 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    chk("t6_pwrup_hold", n >= PWR, 1);
    build_exp(-1, 0);
    run_check("t6");

    // Random NACK patterns with random engine latency
    lat_min = 5; lat_max = 60;
    for (int it = 0; it < 3; it++) begin
      ne = int'($urandom_range(TL - 1, 0));
      nk = int'($urandom_range(4, 0));
      nack_entry = ne; nacks_left = nk;
      do_reset();
      build_exp(ne, nk);
      run_check($sformatf("rnd%0d", it));
      check_gaps($sformatf("rnd%0d", it));
    end

    chk("req_width", wide_req, 0);
    chk("data_stable", unstable, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
